// File: rtl/multiport_register_file_if.sv
// Bus bundle for multiport_register_file: packed read/write address and data
// lanes, per-port write enables and the registered write-conflict flag.
interface multiport_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0]  readRegister;
  logic [NUM_READ*DATA_WIDTH-1:0]  readData;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] writeRegister;
  logic [NUM_WRITE*DATA_WIDTH-1:0] writeData;
  logic [NUM_WRITE-1:0]            WE;
  logic                            writeConflict;

  modport master (
    output readRegister, writeRegister, writeData, WE,
    input  readData, writeConflict
  );

  modport slave (
    input  readRegister, writeRegister, writeData, WE,
    output readData, writeConflict
  );
endinterface

// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file: asynchronous reads, synchronous writes,
// optional write-to-read bypass, optional hardwired zero entry, conflict flag.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic                      clk,
  input logic                      reset,
  multiport_register_file_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]           regs [DEPTH];
  logic [ADDR_WIDTH-1:0]           wAddr [NUM_WRITE];
  logic [DATA_WIDTH-1:0]           wData [NUM_WRITE];
  logic [NUM_WRITE-1:0]            wEff;
  logic                            conflictNext;
  logic                            conflictQ;
  logic [NUM_READ*DATA_WIDTH-1:0]  rdPacked;

  // Enables are pre-filtered so writes to a hardwired zero entry vanish
  // everywhere: storage, bypass and conflict detection alike.
  for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
    assign wAddr[gi] = bus.writeRegister[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wData[gi] = bus.writeData[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wEff[gi]  = bus.WE[gi] && !((ZERO_REG != 0) && (wAddr[gi] == '0));
  end

  always_comb begin
    conflictNext = 1'b0;
    for (int unsigned i = 0; i < NUM_WRITE; i++) begin
      for (int unsigned j = i + 1; j < NUM_WRITE; j++) begin
        if (wEff[i] && wEff[j] && (wAddr[i] == wAddr[j])) conflictNext = 1'b1;
      end
    end
  end

  // Ascending port order: the last non-blocking write wins, giving the
  // highest enabled port priority on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned e = 0; e < DEPTH; e++) regs[e] <= '0;
      conflictQ <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_WRITE; i++) begin
        if (wEff[i]) regs[wAddr[i]] <= wData[i];
      end
      conflictQ <= conflictNext;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] rAddr;
    logic [DATA_WIDTH-1:0] rVal;
    rdPacked = '0;
    rAddr    = '0;
    rVal     = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      rAddr = bus.readRegister[k*ADDR_WIDTH +: ADDR_WIDTH];
      rVal  = regs[rAddr];
      if ((BYPASS != 0) && !reset) begin
        for (int unsigned i = 0; i < NUM_WRITE; i++) begin
          if (wEff[i] && (wAddr[i] == rAddr)) rVal = wData[i];
        end
      end
      if ((ZERO_REG != 0) && (rAddr == '0)) rVal = '0;
      rdPacked[k*DATA_WIDTH +: DATA_WIDTH] = rVal;
    end
  end

  assign bus.readData      = rdPacked;
  assign bus.writeConflict = conflictQ;
endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file share
// identical stimulus; each is checked against hand-computed values.
module tb_multiport_register_file;
  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   failed;

  multiport_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2)) ifB ();
  multiport_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2)) ifN ();

  multiport_register_file #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)
  ) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));

  multiport_register_file #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0), .ZERO_REG(1)
  ) dutN (.clk(clk), .reset(reset), .bus(ifN.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    ifB.WE = we;             ifN.WE = we;
    ifB.writeRegister = {a1, a0}; ifN.writeRegister = {a1, a0};
    ifB.writeData = {d1, d0};     ifN.writeData = {d1, d0};
  endtask

  task automatic setRead(input logic [4:0] r0, input logic [4:0] r1);
    ifB.readRegister = {r1, r0};
    ifN.readRegister = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdB(input int k);
    return ifB.readData[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdN(input int k);
    return ifN.readData[k*32 +: 32];
  endfunction

  initial begin
    total = 0; passed = 0; failed = 0;
    reset = 1'b1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    setRead(5'd0, 5'd0);
    tick();
    tick();

    // 1: random writes, then two reset cycles, then full readback
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, 5'($urandom_range(31)), $urandom, 5'($urandom_range(31)), $urandom);
      tick();
    end
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      setRead(5'(a), 5'(31 - a));
      #1;
      check($sformatf("rst_B_p0_a%0d", a), rdB(0), 32'd0);
      check($sformatf("rst_B_p1_a%0d", 31 - a), rdB(1), 32'd0);
      check($sformatf("rst_N_p0_a%0d", a), rdN(0), 32'd0);
      check($sformatf("rst_N_p1_a%0d", 31 - a), rdN(1), 32'd0);
    end
    check("rst_conflict_B", {31'd0, ifB.writeConflict}, 32'd0);
    check("rst_conflict_N", {31'd0, ifN.writeConflict}, 32'd0);

    // 2: dual write in one cycle
    tick();
    drive(2'b11, 5'd1, 32'd123, 5'd2, 32'd456);
    setRead(5'd1, 5'd2);
    #1;
    check("wr_same_N_p0", rdN(0), 32'd0);
    check("wr_same_N_p1", rdN(1), 32'd0);
    check("wr_same_B_p0", rdB(0), 32'd123);
    check("wr_same_B_p1", rdB(1), 32'd456);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("wr_next_N_p0", rdN(0), 32'd123);
    check("wr_next_N_p1", rdN(1), 32'd456);
    check("wr_next_B_p0", rdB(0), 32'd123);
    check("wr_next_B_p1", rdB(1), 32'd456);
    check("wr_noconflict", {31'd0, ifB.writeConflict}, 32'd0);

    // 3: bypass on port 0 only
    drive(2'b01, 5'd3, 32'd789, 5'd9, 32'd999);
    setRead(5'd3, 5'd9);
    #1;
    check("byp_same_B", rdB(0), 32'd789);
    check("byp_same_N", rdN(0), 32'd0);
    check("byp_disabled_port_B", rdB(1), 32'd0);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("byp_next_B", rdB(0), 32'd789);
    check("byp_next_N", rdN(0), 32'd789);
    check("byp_next_a9_N", rdN(1), 32'd0);

    // 4: same-address conflict, highest port wins
    drive(2'b11, 5'd5, 32'h0000AAAA, 5'd5, 32'h00005555);
    setRead(5'd5, 5'd5);
    #1;
    check("cfl_same_B", rdB(0), 32'h00005555);
    check("cfl_same_N", rdN(1), 32'd0);
    tick();
    drive(2'b00, 5'd5, 32'hFFFFFFFF, 5'd5, 32'hEEEEEEEE);
    #1;
    check("cfl_data_N", rdN(0), 32'h00005555);
    check("cfl_data_B", rdB(1), 32'h00005555);
    check("cfl_flag_B", {31'd0, ifB.writeConflict}, 32'd1);
    check("cfl_flag_N", {31'd0, ifN.writeConflict}, 32'd1);
    tick();
    check("cfl_drop_B", {31'd0, ifB.writeConflict}, 32'd0);
    check("cfl_we0_data_N", rdN(0), 32'h00005555);

    // back-to-back conflicts on addr6 keep the flag high
    drive(2'b11, 5'd6, 32'd10, 5'd6, 32'd20);
    setRead(5'd6, 5'd5);
    tick();
    drive(2'b11, 5'd6, 32'd30, 5'd6, 32'd40);
    #1;
    check("b2b_flag1", {31'd0, ifN.writeConflict}, 32'd1);
    check("b2b_mid_N", rdN(0), 32'd20);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("b2b_flag2", {31'd0, ifN.writeConflict}, 32'd1);
    check("b2b_data_N", rdN(0), 32'd40);
    tick();
    check("b2b_flag_end", {31'd0, ifN.writeConflict}, 32'd0);

    // 5: zero register
    drive(2'b11, 5'd0, 32'd111, 5'd0, 32'd111);
    setRead(5'd0, 5'd0);
    #1;
    check("zero_same_B", rdB(0), 32'd0);
    check("zero_same_N", rdN(1), 32'd0);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("zero_next_B", rdB(1), 32'd0);
    check("zero_next_N", rdN(0), 32'd0);
    check("zero_conflict_B", {31'd0, ifB.writeConflict}, 32'd0);

    // 6: reset coinciding with a write to a non-zero entry
    drive(2'b10, 5'd0, 32'd0, 5'd7, 32'h77);
    tick();
    reset = 1'b1;
    drive(2'b01, 5'd7, 32'd42, 5'd0, 32'd0);
    setRead(5'd7, 5'd1);
    #1;
    check("rmid_old_B", rdB(0), 32'h77);
    check("rmid_old_N", rdN(0), 32'h77);
    check("rmid_a1_B", rdB(1), 32'd123);
    tick();
    reset = 1'b0;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("rmid_clr_B", rdB(0), 32'd0);
    check("rmid_clr_N", rdN(0), 32'd0);
    check("rmid_clr_a1_N", rdN(1), 32'd0);
    check("rmid_conflict", {31'd0, ifB.writeConflict}, 32'd0);
    tick();
    check("rmid_never_B", rdB(0), 32'd0);
    check("rmid_never_N", rdN(0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the single-cycle MIPS register file.
- Configurable data width, depth, number of read ports and number of write ports.
- Optional same-cycle write-to-read bypass, optional hardwired zero register, synchronous clear of all entries.
- Registered write-conflict flag for dual-issue/multi-cycle datapath experiments; drops into the single-cycle core with NUM_READ=2, NUM_WRITE=1.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH entries
NUM_READ, 2, number of asynchronous read ports (1..4)
NUM_WRITE, 2, number of synchronous write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see storage only
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high clear
readRegister  input  NUM_READ*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
readData  output  NUM_READ*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
writeRegister  input  NUM_WRITE*ADDR_WIDTH  write addresses, port i packed as above
writeData  input  NUM_WRITE*DATA_WIDTH  write data, port i packed as above
WE  input  NUM_WRITE  per-port write enable
writeConflict  output  1  registered; high for one cycle after a same-address multi-write

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset:
  - While reset is high at a rising edge, all entries become 0 and writeConflict becomes 0.
  - All writes in that cycle are discarded.
  - Reset held N cycles keeps everything at 0; the first write is accepted on the first edge with reset low.
- Reads:
  - Combinational, zero latency.
  - readData[k] = storage[readRegister[k]], subject to the bypass and zero rules below.
- Writes:
  - On a rising edge with reset low, for each i with WE[i]=1, storage[writeRegister[i]] <= writeData[i].
  - With BYPASS=0, new data is visible on reads in the next cycle.
- Write priority: if several enabled ports target the same address in one cycle, the highest port index wins. Lower-index data is dropped.
- Conflict flag:
  - writeConflict <= 1 at the edge where ≥2 enabled ports hit the same address, else 0.
  - It is a one-cycle pulse per conflicting cycle; back-to-back conflicts hold it high.
  - With ZERO_REG=1, collisions on address 0 do not count.
- Bypass (BYPASS=1):
  - When reset is low, readData[k] = writeData[i] of the highest-index enabled port with writeRegister[i]==readRegister[k].
  - If no port matches, readData[k] falls back to storage.
  - Bypass is disabled while reset is high; reads then return pre-clear storage.
- Zero register (ZERO_REG=1):
  - Address 0 always reads 0, including under bypass.
  - Writes to address 0 are ignored, and address 0 is never bypassed.
- Read ports are independent. Any number may read the same address, including an address being written.
- X/unused: with WE[i]=0, writeRegister[i] and writeData[i] have no effect and cause no conflict.

Test Plan:
1. Reset then readback, defaults: assert reset 2 cycles after random writes -> all 32 entries read 0; writeConflict=0.
2. Basic write/read, BYPASS=0: write port0 addr1=123, port1 addr2=456 in one cycle. Next cycle read ports 0/1 at addr1/addr2 -> 123/456; same-cycle reads still return old value 0.
3. Bypass, BYPASS=1: WE[0]=1, addr3=789, readRegister[0]=3 in the same cycle -> readData[0]=789 before the edge; after the edge storage also holds 789.
4. Conflict: both ports write addr5 (port0=0xAAAA, port1=0x5555) -> addr5=0x5555 next cycle; writeConflict=1 for exactly one cycle, then 0.
5. Zero register: write addr0=111 on port0 and port1 simultaneously, BYPASS=1, read addr0 -> readData=0 both during and after the cycle; writeConflict stays 0.
6. Reset mid-operation: assert reset in the same cycle as a write of addr7=42 while reading addr7 -> read returns old storage (not 42); after the edge addr7=0; the write of 42 is never stored.
